// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit, 7-segment display path: bus widths,
// active-low glyph patterns {g,f,e,d,c,b,a} and the capture FSM state type.
package seg7_pkg;

    localparam int AN_NUM   = 8;
    localparam int CATH_NUM = 7;

    localparam logic [CATH_NUM-1:0] GLYPH_0     = 7'b1000000;
    localparam logic [CATH_NUM-1:0] GLYPH_1     = 7'b1111001;
    localparam logic [CATH_NUM-1:0] GLYPH_2     = 7'b0100100;
    localparam logic [CATH_NUM-1:0] GLYPH_3     = 7'b0110000;
    localparam logic [CATH_NUM-1:0] GLYPH_4     = 7'b0011001;
    localparam logic [CATH_NUM-1:0] GLYPH_5     = 7'b0010010;
    localparam logic [CATH_NUM-1:0] GLYPH_6     = 7'b0000010;
    localparam logic [CATH_NUM-1:0] GLYPH_7     = 7'b1111000;
    localparam logic [CATH_NUM-1:0] GLYPH_8     = 7'b0000000;
    localparam logic [CATH_NUM-1:0] GLYPH_9     = 7'b0010000;
    localparam logic [CATH_NUM-1:0] GLYPH_A     = 7'b0001000;
    localparam logic [CATH_NUM-1:0] GLYPH_B     = 7'b0000011;
    localparam logic [CATH_NUM-1:0] GLYPH_C     = 7'b1000110;
    localparam logic [CATH_NUM-1:0] GLYPH_D     = 7'b0100001;
    localparam logic [CATH_NUM-1:0] GLYPH_E     = 7'b0000110;
    localparam logic [CATH_NUM-1:0] GLYPH_F     = 7'b0001110;
    localparam logic [CATH_NUM-1:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } seg7_cap_state_t;

    // Forward mapping used by the display driver side of the path.
    function automatic logic [CATH_NUM-1:0] seg7_glyph(input logic [3:0] nibble);
        logic [CATH_NUM-1:0] pattern;
        case (nibble)
            4'h0:    pattern = GLYPH_0;
            4'h1:    pattern = GLYPH_1;
            4'h2:    pattern = GLYPH_2;
            4'h3:    pattern = GLYPH_3;
            4'h4:    pattern = GLYPH_4;
            4'h5:    pattern = GLYPH_5;
            4'h6:    pattern = GLYPH_6;
            4'h7:    pattern = GLYPH_7;
            4'h8:    pattern = GLYPH_8;
            4'h9:    pattern = GLYPH_9;
            4'hA:    pattern = GLYPH_A;
            4'hB:    pattern = GLYPH_B;
            4'hC:    pattern = GLYPH_C;
            4'hD:    pattern = GLYPH_D;
            4'hE:    pattern = GLYPH_E;
            default: pattern = GLYPH_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_capture_decode.sv
// Combinational reverse glyph lookup: active-low cathode pattern to hex nibble,
// with flags for a legal hex glyph and for an all-off (blank) digit.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [CATH_NUM-1:0] cath_i,
    output logic [3:0]          nibble_o,
    output logic                valid_o,
    output logic                blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b1;
        blank_o  = 1'b0;
        case (cath_i)
            GLYPH_0:     nibble_o = 4'h0;
            GLYPH_1:     nibble_o = 4'h1;
            GLYPH_2:     nibble_o = 4'h2;
            GLYPH_3:     nibble_o = 4'h3;
            GLYPH_4:     nibble_o = 4'h4;
            GLYPH_5:     nibble_o = 4'h5;
            GLYPH_6:     nibble_o = 4'h6;
            GLYPH_7:     nibble_o = 4'h7;
            GLYPH_8:     nibble_o = 4'h8;
            GLYPH_9:     nibble_o = 4'h9;
            GLYPH_A:     nibble_o = 4'hA;
            GLYPH_B:     nibble_o = 4'hB;
            GLYPH_C:     nibble_o = 4'hC;
            GLYPH_D:     nibble_o = 4'hD;
            GLYPH_E:     nibble_o = 4'hE;
            GLYPH_F:     nibble_o = 4'hF;
            GLYPH_BLANK: begin
                valid_o = 1'b0;
                blank_o = 1'b1;
            end
            default:     valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Display-bus monitor: synchronizes the anode/cathode pins, waits for each
// combination to settle, decodes the glyph and rebuilds the shown 32-bit value.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4
)
(
    input  logic                clk_i,
    input  logic                rst,
    input  logic [AN_NUM-1:0]   an_i,
    input  logic [CATH_NUM-1:0] cath_i,
    output logic [4*AN_NUM-1:0] num_o,
    output logic [AN_NUM-1:0]   digit_valid_o,
    output logic [AN_NUM-1:0]   blank_o,
    output logic [AN_NUM-1:0]   bad_o,
    output logic                frame_o,
    output logic                err_o
);

    localparam logic [7:0] SETTLE_MAX = SETTLE_CYC[7:0];
    localparam logic [7:0] SETTLE_M1  = SETTLE_MAX - 8'd1;

    logic [AN_NUM-1:0]   anMeta_q,   anSync_q,   anPrev_q;
    logic [CATH_NUM-1:0] cathMeta_q, cathSync_q, cathPrev_q;
    logic [7:0]          stab_q,     stab_d;
    seg7_cap_state_t     state_q,    state_d;
    logic [4*AN_NUM-1:0] num_q,      num_d;
    logic [AN_NUM-1:0]   valid_q,    valid_d;
    logic [AN_NUM-1:0]   blank_q,    blank_d;
    logic [AN_NUM-1:0]   bad_q,      bad_d;
    logic [AN_NUM-1:0]   seen_q,     seen_d;
    logic                frame_q,    frame_d;
    logic                err_q,      err_d;

    logic                inputChanged;
    logic                settled;
    logic [AN_NUM-1:0]   anActive;
    logic                anOneHot;
    logic                anMulti;
    logic [2:0]          digitIdx;
    logic                doCapture;
    logic [AN_NUM-1:0]   seenNext;
    logic [3:0]          decNibble;
    logic                decValid;
    logic                decBlank;

    seg7_glyph_decode u_decode (
        .cath_i   (cathSync_q),
        .nibble_o (decNibble),
        .valid_o  (decValid),
        .blank_o  (decBlank)
    );

    // Synchronizers and the previous-sample copy reset to the idle bus so
    // that leaving reset never looks like an input change.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            anMeta_q   <= '1;
            anSync_q   <= '1;
            anPrev_q   <= '1;
            cathMeta_q <= '1;
            cathSync_q <= '1;
            cathPrev_q <= '1;
            stab_q     <= '0;
        end else begin
            anMeta_q   <= an_i;
            anSync_q   <= anMeta_q;
            anPrev_q   <= anSync_q;
            cathMeta_q <= cath_i;
            cathSync_q <= cathMeta_q;
            cathPrev_q <= cathSync_q;
            stab_q     <= stab_d;
        end
    end

    assign inputChanged = (anSync_q != anPrev_q) || (cathSync_q != cathPrev_q);
    assign stab_d       = inputChanged ? 8'd0 :
                          (stab_q >= SETTLE_MAX) ? SETTLE_MAX : stab_q + 8'd1;
    // Settled means the counter reaches SETTLE_CYC on this edge, so the
    // capture registers load together with the counter hitting its limit.
    assign settled      = !inputChanged && (stab_q >= SETTLE_M1);

    assign anActive = ~anSync_q;
    assign anOneHot = (anActive != '0) && ((anActive & (anActive - 8'd1)) == '0);
    assign anMulti  = (anActive != '0) && !anOneHot;

    always_comb begin
        digitIdx = 3'd0;
        for (int i = 0; i < AN_NUM; i++) begin
            if (anActive[i]) digitIdx = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        doCapture = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (anOneHot) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settled) begin
                    if (anOneHot) begin
                        doCapture = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        err_d   = anMulti;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (inputChanged) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture and frame bookkeeping; the completing digit is folded into
    // seen before the all-ones test so it belongs to the frame it closes.
    always_comb begin
        num_d    = num_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        bad_d    = bad_q;
        seen_d   = seen_q;
        seenNext = seen_q;
        frame_d  = 1'b0;
        if (doCapture) begin
            seenNext = seen_q | (8'd1 << digitIdx);
            valid_d[digitIdx] = decValid;
            blank_d[digitIdx] = decBlank;
            bad_d[digitIdx]   = !decValid && !decBlank;
            if (decValid) num_d[{digitIdx, 2'b00} +: 4] = decNibble;
            if (seenNext == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seenNext;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            valid_q <= '0;
            blank_q <= '0;
            bad_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            bad_q   <= bad_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign num_o         = num_q;
    assign digit_valid_o = valid_q;
    assign blank_o       = blank_q;
    assign bad_o         = bad_q;
    assign frame_o       = frame_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized
// digits, compared against a table-driven model of what the display shows.
module tb_seg7_capture;

    localparam int S = 4;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  an_i  = 8'hFF;
    logic [6:0]  cath_i = 7'h7F;
    logic [31:0] num_o;
    logic [7:0]  digit_valid_o;
    logic [7:0]  blank_o;
    logic [7:0]  bad_o;
    logic        frame_o;
    logic        err_o;

    seg7_capture #(.SETTLE_CYC(S)) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .an_i          (an_i),
        .cath_i        (cath_i),
        .num_o         (num_o),
        .digit_valid_o (digit_valid_o),
        .blank_o       (blank_o),
        .bad_o         (bad_o),
        .frame_o       (frame_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;
    int frameCount  = 0;
    int errCount    = 0;

    // Pulse counters sampled mid-cycle; a stretched pulse counts twice.
    always @(negedge clk_i) begin
        if (frame_o === 1'b1) frameCount++;
        if (err_o === 1'b1) errCount++;
    end

    // Reference glyph table, index = hex value.
    logic [6:0] glyphTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [31:0] mNum;
    bit   [7:0]  mValid, mBlank, mBad, mSeen;
    int          mFrames = 0;

    function automatic bit isGlyph(input logic [6:0] c);
        for (int i = 0; i < 16; i++) if (glyphTab[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mNum = '0; mValid = '0; mBlank = '0; mBad = '0; mSeen = '0;
    endtask

    // What the display shows after digit k settles on pattern c.
    task automatic modelCapture(input int k, input logic [6:0] c);
        int hit;
        hit = -1;
        for (int i = 0; i < 16; i++) if (glyphTab[i] == c) hit = i;
        mValid[k] = (hit >= 0);
        mBlank[k] = (hit < 0) && (c == 7'h7F);
        mBad[k]   = (hit < 0) && (c != 7'h7F);
        if (hit >= 0) mNum[4*k +: 4] = 4'(hit);
        mSeen[k] = 1'b1;
        if (mSeen == 8'hFF) begin
            mFrames++;
            mSeen = '0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] an, input logic [6:0] cath);
        @(posedge clk_i);
        #1;
        an_i   = an;
        cath_i = cath;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] anOf(input int k);
        logic [7:0] a;
        a = 8'h01 << k;
        return ~a;
    endfunction

    // Blank the bus long enough to settle, then show one digit until captured.
    task automatic showDigit(input int k, input logic [6:0] c);
        applyStimulus(8'hFF, 7'h7F);
        waitCycles(S + 4);
        applyStimulus(anOf(k), c);
        waitCycles(S + 4);
        modelCapture(k, c);
    endtask

    task automatic resetDut();
        an_i = 8'hFF;
        cath_i = 7'h7F;
        rst = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        resetDut();
        waitCycles(2);
        vectors++; if (num_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_num: got %h expected %h", num_o, 32'h0); end
        vectors++; if (digit_valid_o !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_valid: got %h expected 00", digit_valid_o); end
        vectors++; if (blank_o !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_blank: got %h expected 00", blank_o); end
        vectors++; if (bad_o !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_bad: got %h expected 00", bad_o); end
        vectors++; if (frame_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame: got %b expected 0", frame_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    endtask

    task automatic test_single_digit();
        applyStimulus(8'b11111011, 7'b0110000);
        // One edge before the capture edge E+2+S nothing may have changed yet.
        waitCycles(S + 2);
        vectors++; if (digit_valid_o[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_valid: got %b expected 0", digit_valid_o[2]); end
        vectors++; if (num_o[11:8] !== mNum[11:8]) begin miscompares++; $display("[TB] FAIL single_early_num: got %h expected %h", num_o[11:8], mNum[11:8]); end
        waitCycles(1);
        vectors++; if (num_o[11:8] !== 4'h3) begin miscompares++; $display("[TB] FAIL single_num: got %h expected 3", num_o[11:8]); end
        vectors++; if (digit_valid_o[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %b expected 1", digit_valid_o[2]); end
        modelCapture(2, 7'b0110000);
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            vectors++; if ({num_o, digit_valid_o} !== {mNum, mValid}) begin miscompares++; $display("[TB] FAIL single_hold: got %h/%h expected %h/%h", num_o, digit_valid_o, mNum, mValid); end
        end
    endtask

    task automatic test_bad_blank();
        showDigit(5, 7'b1010101);
        vectors++; if (bad_o[5] !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_flag: got %b expected 1", bad_o[5]); end
        vectors++; if (num_o[23:20] !== mNum[23:20]) begin miscompares++; $display("[TB] FAIL bad_num: got %h expected %h", num_o[23:20], mNum[23:20]); end
        vectors++; if (digit_valid_o[5] !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_valid: got %b expected 0", digit_valid_o[5]); end
        showDigit(5, 7'b1111111);
        vectors++; if (blank_o[5] !== 1'b1) begin miscompares++; $display("[TB] FAIL blank_flag: got %b expected 1", blank_o[5]); end
        vectors++; if (bad_o[5] !== 1'b0) begin miscompares++; $display("[TB] FAIL blank_bad: got %b expected 0", bad_o[5]); end
    endtask

    task automatic test_illegal_anode();
        int e0;
        e0 = errCount;
        applyStimulus(8'b11110011, 7'b0110000);
        waitCycles(S + 10);
        vectors++; if (errCount - e0 !== 1) begin miscompares++; $display("[TB] FAIL illegal_err_pulses: got %0d expected 1", errCount - e0); end
        vectors++; if ({num_o, digit_valid_o, blank_o, bad_o} !== {mNum, mValid, mBlank, mBad}) begin miscompares++; $display("[TB] FAIL illegal_no_capture: got %h %h %h %h expected %h %h %h %h", num_o, digit_valid_o, blank_o, bad_o, mNum, mValid, mBlank, mBad); end
        applyStimulus(8'hFF, 7'h7F);
        waitCycles(S + 6);
        vectors++; if (errCount - e0 !== 1) begin miscompares++; $display("[TB] FAIL illegal_err_after_idle: got %0d expected 1", errCount - e0); end
    endtask

    task automatic test_glitch();
        int e0;
        showDigit(0, glyphTab[7]);
        e0 = errCount;
        applyStimulus(8'hFE, glyphTab[8]);
        @(posedge clk_i);
        applyStimulus(8'hFE, glyphTab[7]);
        for (int i = 0; i < 2 * S + 6; i++) begin
            waitCycles(1);
            vectors++; if (num_o[3:0] !== 4'h7) begin miscompares++; $display("[TB] FAIL glitch_hold: got %h expected 7", num_o[3:0]); end
        end
        modelCapture(0, glyphTab[7]);
        applyStimulus(8'hFE, glyphTab[8]);
        waitCycles(S + 2);
        vectors++; if (num_o[3:0] !== 4'h7) begin miscompares++; $display("[TB] FAIL glitch_early: got %h expected 7", num_o[3:0]); end
        waitCycles(1);
        vectors++; if (num_o[3:0] !== 4'h8) begin miscompares++; $display("[TB] FAIL glitch_settled: got %h expected 8", num_o[3:0]); end
        vectors++; if (errCount !== e0) begin miscompares++; $display("[TB] FAIL glitch_err: got %0d expected %0d", errCount, e0); end
        modelCapture(0, glyphTab[8]);
    endtask

    task automatic test_random();
        int k, r;
        logic [6:0] c;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            if (r < 8) c = glyphTab[$urandom_range(0, 15)];
            else if (r == 8) c = 7'h7F;
            else begin
                c = 7'b1010101;
                for (int t = 0; t < 50; t++) begin
                    c = 7'($urandom);
                    if (!isGlyph(c) && c != 7'h7F) break;
                end
                if (isGlyph(c) || c == 7'h7F) c = 7'b1010101;
            end
            showDigit(k, c);
            vectors++; if (num_o !== mNum) begin miscompares++; $display("[TB] FAIL rand_num: got %h expected %h", num_o, mNum); end
            vectors++; if (digit_valid_o !== mValid) begin miscompares++; $display("[TB] FAIL rand_valid: got %h expected %h", digit_valid_o, mValid); end
            vectors++; if (blank_o !== mBlank) begin miscompares++; $display("[TB] FAIL rand_blank: got %h expected %h", blank_o, mBlank); end
            vectors++; if (bad_o !== mBad) begin miscompares++; $display("[TB] FAIL rand_bad: got %h expected %h", bad_o, mBad); end
            vectors++; if (frameCount !== mFrames) begin miscompares++; $display("[TB] FAIL rand_frames: got %0d expected %0d", frameCount, mFrames); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int order [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
        resetDut();
        for (int d = 0; d < 5; d++) showDigit(d, glyphTab[d + 1]);
        @(posedge clk_i);
        #3;
        rst = 1'b1;
        #1;
        vectors++; if ({num_o, digit_valid_o, blank_o, bad_o} !== 56'h0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %h %h %h %h expected all zero", num_o, digit_valid_o, blank_o, bad_o); end
        vectors++; if ({frame_o, err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL midreset_pulses: got %b expected 00", {frame_o, err_o}); end
        an_i = 8'hFF;
        cath_i = 7'h7F;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst = 1'b0;
        modelReset();
        for (int j = 0; j < 8; j++) begin
            showDigit(order[j], glyphTab[order[j] + 8]);
            vectors++; if (frameCount !== mFrames) begin miscompares++; $display("[TB] FAIL midreset_frame_step%0d: got %0d expected %0d", j, frameCount, mFrames); end
        end
        vectors++; if (num_o !== mNum) begin miscompares++; $display("[TB] FAIL midreset_num: got %h expected %h", num_o, mNum); end
    endtask

    task automatic test_loopback();
        logic [31:0] shown;
        int f0;
        shown = 32'hDEADBEEF;
        resetDut();
        f0 = frameCount;
        for (int rot = 0; rot < 2; rot++) begin
            for (int d = 0; d < 8; d++) begin
                applyStimulus(anOf(d), glyphTab[shown[4*d +: 4]]);
                repeat (19) @(posedge clk_i);
            end
        end
        waitCycles(S + 4);
        vectors++; if (frameCount - f0 !== 2) begin miscompares++; $display("[TB] FAIL loop_frames: got %0d expected 2", frameCount - f0); end
        vectors++; if (num_o !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL loop_num: got %h expected deadbeef", num_o); end
        vectors++; if (digit_valid_o !== 8'hFF) begin miscompares++; $display("[TB] FAIL loop_valid: got %h expected ff", digit_valid_o); end
        vectors++; if ({blank_o, bad_o} !== 16'h0) begin miscompares++; $display("[TB] FAIL loop_flags: got %h %h expected 00 00", blank_o, bad_o); end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single_digit();
        test_bad_blank();
        test_illegal_anode();
        test_glitch();
        test_random();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule
